// File: rtl/sigmoid_rr_scheduler_if.sv
// Requester/result/core-side bundle for the shared sigmoid scheduler.
// slave = scheduler side, master = the requester/downstream/core environment.
interface sigmoid_rr_scheduler_if #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      sig_x;
    logic [W-1:0]      sig_y;
    logic              res_valid;
    logic [W-1:0]      res_y;
    logic [IDW-1:0]    res_id;
    logic              res_ready;
    logic              busy;

    modport slave (
        input  req_valid, req_x, sig_y, res_ready,
        output req_ready, sig_x, res_valid, res_y, res_id, busy
    );

    modport master (
        output req_valid, req_x, sig_y, res_ready,
        input  req_ready, sig_x, res_valid, res_y, res_id, busy
    );
endinterface

// File: rtl/sigmoid_rr_scheduler.sv
// Round-robin share of one combinational sigmoid core: stage A holds the core
// operand, stage B captures the core result and presents it with backpressure.
module sigmoid_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    sigmoid_rr_scheduler_if.slave  bus
);
    logic           r_a_valid;
    logic [W-1:0]   r_a_x;
    logic [IDW-1:0] r_a_id;
    logic           r_res_valid;
    logic [W-1:0]   r_res_y;
    logic [IDW-1:0] r_res_id;
    logic [IDW-1:0] r_ptr;

    logic           w_stall_b;
    logic           w_a_ready;
    logic           w_found;
    logic [IDW-1:0] w_win_id;
    logic           w_xfer;
    logic [W-1:0]   w_sel_x;

    assign w_stall_b = r_res_valid & ~bus.res_ready;
    // Grants are suppressed during reset so nothing is handed out while state clears.
    assign w_a_ready = (~r_a_valid | ~w_stall_b) & ~rst;

    // Scan starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        logic [IDW-1:0] idx;
        idx      = '0;
        w_found  = 1'b0;
        w_win_id = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && bus.req_valid[idx]) begin
                w_found  = 1'b1;
                w_win_id = idx;
            end
        end
    end

    assign w_xfer        = w_a_ready & w_found;
    assign w_sel_x       = bus.req_x[w_win_id*W +: W];
    assign bus.req_ready = w_xfer ? ({{(NREQ-1){1'b0}}, 1'b1} << w_win_id) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid   <= 1'b0;
            r_a_x       <= '0;
            r_a_id      <= '0;
            r_res_valid <= 1'b0;
            r_res_y     <= '0;
            r_res_id    <= '0;
            r_ptr       <= IDW'(NREQ - 1);
        end else begin
            if (!w_stall_b) begin
                r_res_valid <= r_a_valid;
                r_res_y     <= bus.sig_y;
                r_res_id    <= r_a_id;
            end
            // sig_x is deliberately left alone when A empties.
            if (w_xfer) begin
                r_a_valid <= 1'b1;
                r_a_x     <= w_sel_x;
                r_a_id    <= w_win_id;
                r_ptr     <= w_win_id;
            end else if (w_a_ready) begin
                r_a_valid <= 1'b0;
            end
        end
    end

    assign bus.sig_x     = r_a_x;
    assign bus.res_valid = r_res_valid;
    assign bus.res_y     = r_res_y;
    assign bus.res_id    = r_res_id;
    assign bus.busy      = r_a_valid | r_res_valid;
endmodule
